// File: rtl/snapshot_capture_ctrl.sv
// Snapshot capture controller: arms on a software start edge, optionally waits
// for a channelizer frame boundary, then streams 2^ADDR_W valid samples into a
// buffer through registered write outputs and reports progress in a status word.
module snapshot_capture_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [31:0]       ctrl_word,
  input  logic              sync_in,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic [31:0]       status_word
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Index of the final word of a capture; the counter is one bit wider so it
  // can hold the full depth once the capture completes.
  localparam logic [ADDR_W:0] LAST_IDX  = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic                start_q;
  logic [ADDR_W:0]     count_q, count_d;
  logic                done_q, done_d;
  logic                bram_we_q, bram_we_d;
  logic [ADDR_W-1:0]   bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0]   bram_din_q, bram_din_d;

  logic start_bit;
  logic sync_mode;
  logic abort;
  logic start_edge;
  logic sync_hit;
  logic accept;
  logic last_word;
  logic unused_ctrl_bits;

  assign start_bit        = ctrl_word[0];
  assign sync_mode        = ctrl_word[1];
  assign abort            = ctrl_word[2];
  assign unused_ctrl_bits = ^ctrl_word[31:3];

  // A start edge compares the live start bit against last cycle's copy.
  assign start_edge = start_bit & ~start_q;

  // The sync cycle itself already belongs to the capture, so a valid sample
  // arriving with sync_in while armed is taken as word 0.
  assign sync_hit  = (state_q == ARMED) & sync_mode & sync_in;
  assign accept    = din_valid & ~abort & ((state_q == CAPTURE) | sync_hit);
  assign last_word = accept & (count_q == LAST_IDX);

  // State, counter, flag and write-port registers; reset re-samples the start
  // bit so a start held high across reset does not look like a new edge.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q     <= IDLE;
      start_q     <= start_bit;
      count_q     <= '0;
      done_q      <= 1'b0;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_bit;
      count_q     <= count_d;
      done_q      <= done_d;
      bram_we_q   <= bram_we_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
    end
  end

  // Next-state selection; abort overrides every other event.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_edge) state_d = ARMED;
        end
        ARMED: begin
          if (!sync_mode) begin
            state_d = CAPTURE;
          end else if (sync_in) begin
            state_d = last_word ? DONE : CAPTURE;
          end
        end
        CAPTURE: begin
          if (last_word) state_d = DONE;
        end
        DONE: begin
          if (start_edge) state_d = ARMED;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Word counter, done flag and next write-port values.
  always_comb begin
    count_d     = count_q;
    done_d      = done_q;
    bram_we_d   = 1'b0;
    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;
    if (abort) begin
      count_d = '0;
      done_d  = 1'b0;
    end else if (((state_q == IDLE) || (state_q == DONE)) && start_edge) begin
      count_d = '0;
      done_d  = 1'b0;
    end else if (accept) begin
      bram_we_d   = 1'b1;
      bram_addr_d = count_q[ADDR_W-1:0];
      bram_din_d  = din;
      count_d     = count_q + COUNT_ONE;
      if (last_word) done_d = 1'b1;
    end
  end

  // Status word assembled from the live registers: count, done flag, state.
  always_comb begin
    status_word                   = '0;
    status_word[16 +: ADDR_W + 1] = count_q;
    status_word[2]                = done_q;
    status_word[1:0]              = state_q;
  end

  assign bram_we   = bram_we_q;
  assign bram_addr = bram_addr_q;
  assign bram_din  = bram_din_q;

endmodule

// File: tb/tb_snapshot_capture_ctrl.sv
// Bench for snapshot_capture_ctrl with a 16-word buffer: a behavioural model
// is checked against the DUT every cycle, and directed scenarios add literal
// expectations on status and buffer contents.
module tb_snapshot_capture_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              user_clk;
  logic              user_rst;
  logic [31:0]       ctrl_word;
  logic              sync_in;
  logic              din_valid;
  logic [DATA_W-1:0] din;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic [31:0]       status_word;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int          m_phase;
  int          m_cnt;
  bit          m_done;
  bit          m_prev_start;
  bit          m_we;
  int          m_addr;
  logic [31:0] m_din;

  // Log of DUT writes
  int          wr_count;
  logic [31:0] wr_mem [DEPTH];

  snapshot_capture_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .user_clk   (user_clk),
    .user_rst   (user_rst),
    .ctrl_word  (ctrl_word),
    .sync_in    (sync_in),
    .din_valid  (din_valid),
    .din        (din),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_din   (bram_din),
    .status_word(status_word)
  );

  // Free-running clock
  initial begin
    user_clk = 1'b0;
    forever #5 user_clk = ~user_clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; they are consumed by the next rising edge
  task automatic applyStimulus(input logic rst, input logic [31:0] ctrl, input logic sync,
                               input logic valid, input logic [31:0] data);
    user_rst  = rst;
    ctrl_word = ctrl;
    sync_in   = sync;
    din_valid = valid;
    din       = data;
    @(negedge user_clk);
  endtask

  function automatic logic [31:0] modelStatus();
    return (32'(m_cnt) << 16) | (32'(m_done) << 2) | 32'(m_phase);
  endfunction

  // Behavioural model: phases 0 idle, 1 armed, 2 capturing, 3 done
  always @(posedge user_clk) begin
    bit edge_seen;
    bit take;
    if (user_rst) begin
      m_phase = 0; m_cnt = 0; m_done = 0; m_we = 0; m_addr = 0; m_din = '0;
      m_prev_start = ctrl_word[0];
    end else begin
      edge_seen    = ctrl_word[0] && !m_prev_start;
      m_prev_start = ctrl_word[0];
      m_we = 0;
      take = 0;
      if (ctrl_word[2]) begin
        m_phase = 0; m_cnt = 0; m_done = 0;
      end else if ((m_phase == 0 || m_phase == 3) && edge_seen) begin
        m_phase = 1; m_cnt = 0; m_done = 0;
      end else if (m_phase == 1 && !ctrl_word[1]) begin
        m_phase = 2;
      end else if (m_phase == 1 && sync_in) begin
        m_phase = 2;
        take = 1;
      end else if (m_phase == 2) begin
        take = 1;
      end
      if (take && din_valid) begin
        m_we = 1; m_addr = m_cnt; m_din = din;
        m_cnt++;
        if (m_cnt == DEPTH) begin
          m_phase = 3; m_done = 1;
        end
      end
    end
  end

  // Compare DUT against the model shortly after every rising edge, and log writes
  always @(posedge user_clk) begin
    #1;
    checkOutput("bram_we", 32'(bram_we), 32'(m_we));
    if (m_we) begin
      checkOutput("bram_addr", 32'(bram_addr), 32'(m_addr));
      checkOutput("bram_din", bram_din, m_din);
    end
    checkOutput("status_word", status_word, modelStatus());
    if (bram_we) begin
      wr_count++;
      wr_mem[bram_addr] = bram_din;
    end
  end

  initial begin
    int k;
    int snap;
    wr_count = 0;
    user_rst = 1'b1; ctrl_word = '0; sync_in = 1'b0; din_valid = 1'b0; din = '0;
    @(negedge user_clk);

    // Reset state
    applyStimulus(1, 32'h0, 0, 0, 32'h0);
    checkOutput("reset_status", status_word, 32'h0000_0000);
    checkOutput("reset_we", 32'(bram_we), 32'h0);
    checkOutput("reset_addr", 32'(bram_addr), 32'h0);
    checkOutput("reset_din", bram_din, 32'h0);
    applyStimulus(0, 32'h0, 0, 0, 32'h0);

    // Immediate capture with a ramp starting at 0x100
    wr_count = 0;
    applyStimulus(0, 32'h1, 0, 1, 32'hDEAD_0001);
    checkOutput("t1_armed", status_word, 32'h0000_0001);
    applyStimulus(0, 32'h1, 0, 1, 32'hDEAD_0002);
    checkOutput("t1_no_write_armed", 32'(wr_count), 32'd0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 32'h1, 0, 1, 32'h100 + 32'(i));
    checkOutput("t1_status_done", status_word, 32'h0010_0007);
    checkOutput("t1_write_count", 32'(wr_count), 32'd16);
    for (int i = 0; i < DEPTH; i++) checkOutput("t1_mem", wr_mem[i], 32'h100 + 32'(i));
    applyStimulus(0, 32'h1, 0, 1, 32'hDEAD_0003);
    applyStimulus(0, 32'h1, 0, 1, 32'hDEAD_0004);
    checkOutput("t1_done_hold", status_word, 32'h0010_0007);
    checkOutput("t1_done_no_write", 32'(wr_count), 32'd16);

    // Sync wait: a sync on the start-edge cycle is ignored, the later one starts capture
    applyStimulus(0, 32'h2, 0, 1, 32'hBAD0_0000);
    wr_count = 0;
    applyStimulus(0, 32'h3, 1, 1, 32'hBAD0_0001);
    for (int i = 0; i < 19; i++) applyStimulus(0, 32'h3, 0, 1, 32'hBAD0_0100 + 32'(i));
    checkOutput("t2_waiting", status_word, 32'h0000_0001);
    checkOutput("t2_no_early_write", 32'(wr_count), 32'd0);
    applyStimulus(0, 32'h3, 1, 1, 32'h200);
    checkOutput("t2_first_write_count", 32'(wr_count), 32'd1);
    checkOutput("t2_word0", wr_mem[0], 32'h200);
    checkOutput("t2_capturing", status_word, 32'h0001_0002);
    for (int i = 1; i < DEPTH; i++) applyStimulus(0, 32'h3, 0, 1, 32'h200 + 32'(i));
    checkOutput("t2_status_done", status_word, 32'h0010_0007);

    // Gapped valid: 16 valid samples spread over 31 capture cycles
    applyStimulus(0, 32'h0, 0, 0, 32'h0);
    wr_count = 0;
    applyStimulus(0, 32'h1, 0, 0, 32'h0);
    applyStimulus(0, 32'h1, 0, 0, 32'h0);
    k = 0;
    for (int i = 0; i < 30; i++) begin
      if (i % 2 == 0) begin
        applyStimulus(0, 32'h1, 0, 1, 32'h300 + 32'(k));
        k++;
      end else begin
        applyStimulus(0, 32'h1, 0, 0, 32'hFFFF_FFFF);
      end
    end
    checkOutput("t3_before_last", status_word, 32'h000F_0002);
    applyStimulus(0, 32'h1, 0, 1, 32'h30F);
    checkOutput("t3_done", status_word, 32'h0010_0007);
    checkOutput("t3_write_count", 32'(wr_count), 32'd16);
    checkOutput("t3_last_word", wr_mem[15], 32'h30F);

    // Re-arm from DONE, then a start edge mid-capture is ignored
    applyStimulus(0, 32'h0, 0, 0, 32'h0);
    applyStimulus(0, 32'h1, 0, 0, 32'h0);
    checkOutput("t4_rearm", status_word, 32'h0000_0001);
    applyStimulus(0, 32'h1, 0, 0, 32'h0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 32'h1, 0, 1, 32'h400 + 32'(i));
    applyStimulus(0, 32'h0, 0, 1, 32'h405);
    applyStimulus(0, 32'h1, 0, 1, 32'h406);
    checkOutput("t4_edge_ignored", status_word, 32'h0007_0002);

    // Abort at count 7: the abort-cycle sample is dropped
    snap = wr_count;
    applyStimulus(0, 32'h5, 0, 1, 32'h0AB);
    checkOutput("t5_abort_status", status_word, 32'h0000_0000);
    checkOutput("t5_abort_we", 32'(bram_we), 32'h0);
    applyStimulus(0, 32'h1, 1, 1, 32'h0AC);
    applyStimulus(0, 32'h1, 0, 1, 32'h0AD);
    checkOutput("t5_idle_stays", status_word, 32'h0000_0000);
    checkOutput("t5_no_writes", 32'(wr_count), 32'(snap));

    // Reset mid-capture with start held high
    applyStimulus(0, 32'h0, 0, 0, 32'h0);
    applyStimulus(0, 32'h1, 0, 0, 32'h0);
    applyStimulus(0, 32'h1, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 32'h1, 0, 1, 32'h500 + 32'(i));
    checkOutput("t6_mid_capture", status_word, 32'h0003_0002);
    applyStimulus(1, 32'h1, 0, 1, 32'h503);
    applyStimulus(1, 32'h1, 0, 1, 32'h504);
    snap = wr_count;
    for (int i = 0; i < 3; i++) applyStimulus(0, 32'h1, 0, 1, 32'h505 + 32'(i));
    checkOutput("t6_no_spurious_start", status_word, 32'h0000_0000);
    checkOutput("t6_no_writes", 32'(wr_count), 32'(snap));
    applyStimulus(0, 32'h0, 0, 1, 32'h0);
    applyStimulus(0, 32'h1, 0, 1, 32'h0);
    checkOutput("t6_arm_again", status_word, 32'h0000_0001);
    applyStimulus(0, 32'h1, 0, 1, 32'h0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 32'h1, 0, 1, 32'h600 + 32'(i));
    checkOutput("t6_done", status_word, 32'h0010_0007);
    checkOutput("t6_word15", wr_mem[15], 32'h60F);

    applyStimulus(0, 32'h1, 0, 0, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
